// File: rtl/fir_sample_ctrl.sv
// Scan-session sequencer for the barcode FIR filter: flushes the filter, paces its sample strobe,
// and buffers each filter result in a small first-word-fall-through FIFO for the MCU side.
module fir_sample_ctrl #(
    parameter int CLK_DIV      = 1000,
    parameter int FLUSH_CYCLES = 2,
    parameter int OUT_WIDTH    = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 fir_done,
    input  logic [OUT_WIDTH-1:0] fir_data,
    output logic                 sample,
    output logic                 fir_reset_n,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 overflow,
    output logic [15:0]          word_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [FW-1:0]        flush_cnt;
    logic [CW-1:0]        div_cnt;
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push_req;
    logic                 push;
    logic                 session_start;

    // The extra pointer bit distinguishes a full FIFO from an empty one when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && out_ready;
    assign push_req = fir_done && ((state == RUN) || (state == DRAIN));
    assign push     = push_req && (!full || pop);

    assign session_start = (state == IDLE) && (state_next == FLUSH);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !stop) state_next = FLUSH;
            end
            FLUSH: begin
                if (stop)                          state_next = DRAIN;
                else if (flush_cnt == FLUSH_LAST)  state_next = RUN;
            end
            RUN: begin
                if (stop) state_next = DRAIN;
            end
            DRAIN: begin
                if (empty) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            div_cnt     <= '0;
            fir_reset_n <= 1'b0;
        end else begin
            state       <= state_next;
            fir_reset_n <= (state_next != FLUSH);

            if ((state == FLUSH) && (state_next == FLUSH)) flush_cnt <= flush_cnt + FW'(1);
            else                                           flush_cnt <= '0;

            // Held at zero outside RUN so every RUN entry begins a fresh sample period.
            if (state == RUN) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
            else              div_cnt <= '0;
        end
    end

    assign sample = (state == RUN) && (div_cnt == DIV_LAST);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= fir_data;
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow   <= 1'b0;
            word_count <= '0;
        end else if (session_start) begin
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (push && (word_count != 16'hFFFF)) word_count <= word_count + 16'd1;
            if (push_req && !push)                overflow   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_sample_ctrl.sv
// Bench for fir_sample_ctrl: scenario tasks plus a queue-based behavioural model of the
// scan session that every cycle's outputs are compared against.
`timescale 1ns/1ps
module tb_fir_sample_ctrl;

    localparam int CLK_DIV      = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int OUT_WIDTH    = 32;
    localparam int FIFO_DEPTH   = 4;

    localparam int P_IDLE  = 0;
    localparam int P_FLUSH = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic        fir_done  = 1'b0;
    logic [31:0] fir_data  = '0;
    logic        out_ready = 1'b0;
    logic        sample;
    logic        fir_reset_n;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_data;
    logic        overflow;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    int          m_phase       = P_IDLE;
    int          m_flush_left  = 0;
    int          m_age         = 0;
    int          m_count       = 0;
    logic        m_ovf         = 1'b0;
    logic        m_frn         = 1'b0;
    logic [31:0] m_q[$];

    fir_sample_ctrl #(
        .CLK_DIV(CLK_DIV), .FLUSH_CYCLES(FLUSH_CYCLES),
        .OUT_WIDTH(OUT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .fir_done(fir_done), .fir_data(fir_data), .sample(sample),
        .fir_reset_n(fir_reset_n), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .overflow(overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Session model: phase plus cycles-since-RUN for the strobe, a queue for the result buffer.
    always @(posedge clk) begin : model_step
        int sz;
        bit pop_now;
        bit push_now;
        sz       = m_q.size();
        pop_now  = (sz > 0) && out_ready;
        push_now = fir_done && (m_phase == P_RUN || m_phase == P_DRAIN);
        if (!reset) begin
            m_phase = P_IDLE; m_q.delete(); m_count = 0; m_ovf = 1'b0;
            m_frn = 1'b0; m_age = 0; m_flush_left = 0;
        end else begin
            if (pop_now) void'(m_q.pop_front());
            if (push_now) begin
                if (sz < FIFO_DEPTH || pop_now) begin
                    m_q.push_back(fir_data);
                    if (m_count < 65535) m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            case (m_phase)
                P_IDLE:  if (start && !stop) begin
                             m_phase = P_FLUSH; m_flush_left = FLUSH_CYCLES; m_count = 0; m_ovf = 1'b0;
                         end
                P_FLUSH: if (stop) m_phase = P_DRAIN;
                         else begin
                             m_flush_left--;
                             if (m_flush_left == 0) begin m_phase = P_RUN; m_age = 0; end
                         end
                P_RUN:   if (stop) m_phase = P_DRAIN; else m_age++;
                default: if (sz == 0) m_phase = P_IDLE;
            endcase
            m_frn = (m_phase != P_FLUSH);
        end
    end

    function automatic logic [52:0] model_vec();
        logic        s;
        logic [15:0] c;
        logic [31:0] d;
        s = (m_phase == P_RUN) && ((m_age % CLK_DIV) == CLK_DIV - 1);
        c = m_count[15:0];
        d = (m_q.size() > 0) ? m_q[0] : 32'h0;
        return {s, m_frn, (m_phase != P_IDLE), (m_q.size() > 0), m_ovf, c, d};
    endfunction

    function automatic logic [52:0] dut_vec();
        return {sample, fir_reset_n, busy, out_valid, overflow, word_count,
                (out_valid ? out_data : 32'h0)};
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 0; stop = 0; fir_done = 0; out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== 53'h0 || out_data !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_values k=%0d got=%h/%h exp=0/0", k, dut_vec(), out_data);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (fir_reset_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got frn=%b busy=%b exp frn=1 busy=0", fir_reset_n, busy);
        end
    endtask

    task automatic test_start_to_sample();
        logic [2:0] exp_v;
        for (int k = 0; k < 22; k++) begin
            start = (k == 0);
            stop  = (k == 18);
            @(negedge clk);
            exp_v = {(k == 5 || k == 9 || k == 13 || k == 17), (k >= 2), (k <= 18)};
            checks++;
            if ({sample, fir_reset_n, busy} !== exp_v) begin
                errors++;
                $display("[TB] FAIL start_timing k=%0d got=%b exp=%b", k, {sample, fir_reset_n, busy}, exp_v);
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL start_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        start = 0; stop = 0;
    endtask

    task automatic test_fifo_order();
        logic [31:0] exp_head;
        for (int k = 0; k < 30; k++) begin
            start     = (k == 0);
            stop      = (k == 25);
            fir_done  = (k == 5 || k == 7 || k == 9);
            fir_data  = (k == 5) ? 32'h11 : (k == 7) ? 32'h22 : 32'h33;
            out_ready = (k >= 14);
            @(negedge clk);
            if (k == 9 || k == 13 || k == 14 || k == 15) begin
                exp_head = (k == 14) ? 32'h22 : (k == 15) ? 32'h33 : 32'h11;
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_head) begin
                    errors++;
                    $display("[TB] FAIL fifo_head k=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, exp_head);
                end
            end
            if (k == 16) begin
                checks++;
                if (out_valid !== 1'b0 || word_count !== 16'd3) begin
                    errors++;
                    $display("[TB] FAIL fifo_empty_count got=%b/%0d exp=0/3", out_valid, word_count);
                end
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL fifo_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        start = 0; stop = 0; fir_done = 0; out_ready = 0;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 28; k++) begin
            start     = (k == 0 || k == 20);
            stop      = (k == 16 || k == 24);
            fir_done  = (k >= 4 && k <= 8) || (k == 10);
            fir_data  = (k == 10) ? 32'hB0 : 32'hA0 + 32'(k);
            out_ready = (k == 10) || (k >= 12);
            @(negedge clk);
            if (k == 8) begin
                checks++;
                if (overflow !== 1'b1 || word_count !== 16'd4 || out_data !== 32'hA4) begin
                    errors++;
                    $display("[TB] FAIL overflow_drop got=%b/%0d/%h exp=1/4/a4", overflow, word_count, out_data);
                end
            end
            if (k == 10) begin
                checks++;
                if (overflow !== 1'b1 || word_count !== 16'd5 || out_data !== 32'hA5) begin
                    errors++;
                    $display("[TB] FAIL full_push_pop got=%b/%0d/%h exp=1/5/a5", overflow, word_count, out_data);
                end
            end
            if (k == 20) begin
                checks++;
                if (overflow !== 1'b0 || word_count !== 16'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL overflow_clear got=%b/%0d/%b exp=0/0/1", overflow, word_count, busy);
                end
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL overflow_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        start = 0; stop = 0; fir_done = 0; out_ready = 0;
    endtask

    task automatic test_stop_drain();
        logic [31:0] exp_head;
        for (int k = 0; k < 20; k++) begin
            start     = (k == 0);
            stop      = (k == 8);
            fir_done  = (k == 4 || k == 5 || k == 9);
            fir_data  = (k == 4) ? 32'hC1 : (k == 5) ? 32'hC2 : 32'hC3;
            out_ready = (k >= 15);
            @(negedge clk);
            if (k >= 8) begin
                checks++;
                if (sample !== 1'b0 || busy !== (k <= 17)) begin
                    errors++;
                    $display("[TB] FAIL drain_ctrl k=%0d got s=%b busy=%b exp s=0 busy=%b", k, sample, busy, (k <= 17));
                end
            end
            if (k >= 14 && k <= 16) begin
                exp_head = (k == 16) ? 32'hC3 : (k == 15) ? 32'hC2 : 32'hC1;
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_head || word_count !== 16'd3) begin
                    errors++;
                    $display("[TB] FAIL drain_word k=%0d got=%b/%h/%0d exp=1/%h/3", k, out_valid, out_data, word_count, exp_head);
                end
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL drain_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        start = 0; stop = 0; fir_done = 0; out_ready = 0;
    endtask

    task automatic test_edges();
        // start during RUN must neither restart the flush nor clear the count
        for (int k = 0; k < 14; k++) begin
            start = (k == 0 || k == 6); stop = (k == 10);
            fir_done = (k == 4); fir_data = 32'hD1; out_ready = (k >= 10);
            @(negedge clk);
            if (k == 6 || k == 7 || k == 9) begin
                checks++;
                if (busy !== 1'b1 || fir_reset_n !== 1'b1 || word_count !== 16'd1 || sample !== (k == 9)) begin
                    errors++;
                    $display("[TB] FAIL start_in_run k=%0d got=%b%b%b/%0d exp=1,1,%b/1", k, busy, fir_reset_n, sample, word_count, (k == 9));
                end
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL edge_run_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        for (int k = 0; k < 4; k++) begin
            start = (k == 0); stop = (k == 0); fir_done = 0; out_ready = 0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || fir_reset_n !== 1'b1) begin
                errors++;
                $display("[TB] FAIL start_stop_idle k=%0d got busy=%b frn=%b exp 0/1", k, busy, fir_reset_n);
            end
        end
        for (int k = 0; k < 8; k++) begin
            start = (k == 0); stop = (k == 1); fir_done = (k == 1); fir_data = 32'hEE;
            @(negedge clk);
            checks++;
            if (sample !== 1'b0 || out_valid !== 1'b0 || busy !== (k <= 1) || fir_reset_n !== (k >= 1)) begin
                errors++;
                $display("[TB] FAIL stop_in_flush k=%0d got s=%b v=%b busy=%b frn=%b", k, sample, out_valid, busy, fir_reset_n);
            end
        end
        start = 0; stop = 0; fir_done = 0; out_ready = 0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 24; k++) begin
            start    = (k == 0 || k == 11);
            stop     = (k == 20);
            reset    = (k != 8);
            fir_done = (k >= 4 && k <= 6);
            fir_data = 32'hF0 + 32'(k);
            out_ready = 1'b0;
            @(negedge clk);
            if (k == 8) begin
                checks++;
                if (dut_vec() !== 53'h0 || out_data !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL mid_reset got=%h/%h exp=0/0", dut_vec(), out_data);
                end
            end
            if (k == 16) begin
                checks++;
                if (sample !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL restart_sample got s=%b busy=%b exp 1/1", sample, busy);
                end
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL mid_reset_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        start = 0; stop = 0; reset = 1; fir_done = 0;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 65560; k++) begin
            start     = (k == 0);
            stop      = (k == 65550);
            fir_done  = (k >= 3 && k < 65545);
            fir_data  = 32'(k);
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL saturate_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        checks++;
        if (word_count !== 16'hFFFF || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL saturate_end got=%h/%b/%b exp=ffff/0/0", word_count, overflow, busy);
        end
        start = 0; stop = 0; fir_done = 0; out_ready = 0;
    endtask

    task automatic test_random();
        int stop_at;
        for (int s = 0; s < 8; s++) begin
            stop_at = $urandom_range(3, 45);
            for (int k = 0; k < 72; k++) begin
                start     = (k == 0) || (k < 58 && $urandom_range(0, 30) == 0);
                stop      = (k == stop_at) || (k == 58) || (k < 58 && $urandom_range(0, 60) == 0);
                fir_done  = (k < 60) && ($urandom_range(0, 2) == 0);
                fir_data  = $urandom;
                out_ready = (k >= 58) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("[TB] FAIL random_model s=%0d k=%0d got=%h exp=%h", s, k, dut_vec(), model_vec());
                end
            end
        end
        start = 0; stop = 0; fir_done = 0; out_ready = 0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_start_to_sample();
        test_fifo_order();
        test_overflow();
        test_stop_drain();
        test_edges();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_sample_ctrl.md
# fir_sample_ctrl

Sequencer for the barcode FIR filter. It owns one scan session from start to end. It flushes the filter and generates the filter's `sample` strobe at a programmable rate. It captures each filter result (`fir_done`/`fir_data`) into a small first-word-fall-through FIFO and presents the words to the MCU-side interface over a valid/ready handshake.

## Interface
- `CLK_DIV`, 1000: clk cycles per sample strobe; legal range ≥ 2.
- `FLUSH_CYCLES`, 2: cycles `fir_reset_n` is held low at scan start; legal range ≥ 1.
- `OUT_WIDTH`, 32: filter result width.
- `FIFO_DEPTH`, 4: result FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  one-cycle request to begin a scan.
- `stop`  in  1  one-cycle request to end a scan.
- `fir_done`  in  1  one-cycle pulse from the filter: `fir_data` is valid.
- `fir_data`  in  `OUT_WIDTH`  filter result.
- `sample`  out  1  one-cycle sample strobe to the filter.
- `fir_reset_n`  out  1  active-low synchronous reset to the filter.
- `busy`  out  1  high whenever state ≠ IDLE.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head word.
- `out_data`  out  `OUT_WIDTH`  FIFO head word.
- `overflow`  out  1  sticky: a result was dropped.
- `word_count`  out  16  results accepted since the last start; saturates at 0xFFFF.

## Operation
- State machine states: IDLE, FLUSH, RUN, DRAIN.
- IDLE:
  - `start` → FLUSH.
  - `start` and `stop` in the same cycle: `stop` wins; the block stays in IDLE.
  - Entering FLUSH from IDLE clears `overflow` and `word_count`.
- FLUSH:
  - `fir_reset_n` = 0 for exactly `FLUSH_CYCLES` cycles, then → RUN.
  - `stop` during FLUSH → DRAIN immediately.
- RUN:
  - The sample counter starts at 0 on entry and counts 0..`CLK_DIV`-1, then wraps.
  - `sample` = 1 exactly in the cycle where counter = `CLK_DIV`-1.
  - `stop` → DRAIN. A `sample` strobe coinciding with `stop` is still issued.
- DRAIN:
  - No `sample` strobes are issued.
  - `fir_done` is still accepted, so a result trailing the last sample is not lost.
  - When the FIFO is empty at the start of a cycle → IDLE.
- `start` outside IDLE is ignored. `stop` in IDLE is ignored.
- `fir_reset_n` = 1 in IDLE, RUN and DRAIN.
- FIFO push:
  - Occurs on `fir_done` in RUN or DRAIN. `fir_done` in IDLE or FLUSH is ignored.
  - The push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - An accepted push increments `word_count`, saturating.
  - A rejected push discards the word and sets `overflow` = 1. `overflow` stays set until the next start.
- FIFO pop:
  - Occurs when `out_valid && out_ready`.
  - `out_data` always shows the head entry; it is undefined when `out_valid` = 0.
  - When empty, a push and pop in the same cycle act only as a push; the word appears the next cycle.
- Pointers are log2(`FIFO_DEPTH`)+1 bits wide, with a wrap bit for full/empty detection.
- Reset mid-operation:
  - Returns to IDLE and empties the FIFO. Stored data is lost.
  - Clears `overflow` and `word_count` and the sample counter.

## Timing
- Reset values:
  - `sample` = 0, `fir_reset_n` = 0, `busy` = 0.
  - `out_valid` = 0, `overflow` = 0, `word_count` = 0.
  - `out_data` = 0.
- `fir_reset_n` rises to 1 the first cycle after reset is released.
- All outputs are registered or decoded from registered state only. No combinational path from `out_ready` to `out_valid`.
- `start` sampled in cycle t:
  - FLUSH in t+1..t+`FLUSH_CYCLES`.
  - RUN entered at t+`FLUSH_CYCLES`+1 (call it R).
  - First `sample` at R+`CLK_DIV`-1, then every `CLK_DIV` cycles.
- `busy` rises at t+1.
- A push on `fir_done` at cycle c gives `out_valid` = 1 and valid `out_data` at c+1. `word_count` updates at c+1.
- A pop at cycle c: the next head, or `out_valid` = 0, appears at c+1.
- DRAIN to IDLE: `busy` falls the cycle after the FIFO is observed empty in DRAIN.

## Test plan
- Start to first sample:
  - Stimulus: reset, then `start` at cycle 10 with `CLK_DIV`=4, `FLUSH_CYCLES`=2.
  - Response: `fir_reset_n` low at cycles 11–12; RUN at 13; `sample` at 16, 20, 24; `busy` high from 11.
- FIFO order:
  - Stimulus: in RUN with `out_ready`=0, pulse `fir_done` with data 0x11, 0x22, 0x33.
  - Response: `out_valid`=1, `out_data`=0x11; then raise `out_ready`; words pop in order 0x11, 0x22, 0x33; `word_count`=3.
- Overflow and simultaneous push/pop:
  - Stimulus: with `FIFO_DEPTH`=4 and `out_ready`=0, push 5 words.
  - Response: the 5th word is dropped and `overflow`=1.
  - Stimulus: with the FIFO full, push and pop in the same cycle.
  - Response: the push is accepted; `word_count`=5 at the end; `overflow` clears on the next start.
- Stop and drain:
  - Stimulus: `stop` in RUN with 2 words queued; `fir_done` arrives 1 cycle after `stop`.
  - Response: no further `sample` strobes; 3 words are delivered; `busy` falls only after the last pop.
- Edge requests:
  - Stimulus: `start` during RUN.
  - Response: ignored.
  - Stimulus: `start` and `stop` together in IDLE.
  - Response: stays in IDLE.
  - Stimulus: `stop` during FLUSH.
  - Response: → DRAIN → IDLE with no sample issued.
- Reset mid-scan:
  - Stimulus: `reset` low for 1 cycle in RUN with the FIFO holding 3 words.
  - Response: all outputs return to their reset values; the next `start` works normally.
